arbiter_demux_32_8: RTL

ARBITER_DEMUX_32_8 -- requirements
Module: arbiter_demux_32_8

---
 rtl/arbiter_demux_32_8.sv | 118 +++++++++++
 1 files changed

// File: rtl/arbiter_demux_32_8.sv
// Two-requester round-robin arbiter that serializes each accepted 32-bit word onto an 8-bit lane.
// Define IDLE_FILL_EN to drive 8'hBC as the idle byte instead of 8'h00.
module arbiter_demux_32_8 (
  input  logic        clk_4f,
  input  logic        reset,
  input  logic        valid_0,
  input  logic [31:0] data_in_0,
  output logic        ready_0,
  input  logic        valid_1,
  input  logic [31:0] data_in_1,
  output logic        ready_1,
  output logic [7:0]  data_out,
  output logic        valid_out,
  output logic        grant,
  output logic        busy
);

`ifdef IDLE_FILL_EN
  localparam logic [7:0] IdleByte = 8'hBC;
`else
  localparam logic [7:0] IdleByte = 8'h00;
`endif

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        valid_out_q, valid_out_d;
  logic        busy_q, busy_d;
  logic        grant_q, grant_d;
  logic        last_q, last_d;

  logic        slot;
  logic        sel;
  logic        take;
  logic [31:0] word_in;

  always_comb begin
    slot = (state_q == StIdle) || ((state_q == StSend) && (cnt_q == 2'd3));
    // On a tie the requester not granted last wins; otherwise the lone requester wins.
    if (valid_0 && valid_1) begin
      sel = ~last_q;
    end else begin
      sel = valid_1;
    end
    take    = slot && (valid_0 || valid_1) && !reset;
    ready_0 = take && !sel;
    ready_1 = take && sel;
    word_in = sel ? data_in_1 : data_in_0;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    data_out_d  = data_out_q;
    valid_out_d = valid_out_q;
    busy_d      = busy_q;
    grant_d     = grant_q;
    last_d      = last_q;
    if (take) begin
      state_d     = StSend;
      cnt_d       = 2'd0;
      word_d      = word_in;
      grant_d     = sel;
      last_d      = sel;
      data_out_d  = word_in[31:24];
      valid_out_d = 1'b1;
      busy_d      = 1'b1;
    end else if (state_q == StSend) begin
      if (cnt_q != 2'd3) begin
        cnt_d = cnt_q + 2'd1;
        unique case (cnt_d)
          2'd1:    data_out_d = word_q[23:16];
          2'd2:    data_out_d = word_q[15:8];
          2'd3:    data_out_d = word_q[7:0];
          default: data_out_d = word_q[31:24];
        endcase
      end else begin
        state_d     = StIdle;
        cnt_d       = 2'd0;
        data_out_d  = IdleByte;
        valid_out_d = 1'b0;
        busy_d      = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= 2'd0;
      word_q      <= 32'h0;
      data_out_q  <= IdleByte;
      valid_out_q <= 1'b0;
      busy_q      <= 1'b0;
      grant_q     <= 1'b0;
      last_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      busy_q      <= busy_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign busy      = busy_q;
  assign grant     = grant_q;

endmodule
